product_list_scheduler: RTL and testbench
=========================================

// Module: product_list_scheduler
// PURPOSE
// - Owns the 12-slot product ID list shown on the VGA text display.
// - Drives the 48-bit product_IDS bus consumed by text_controller.
// - Applies add / remove-last / clear commands from the terminal front-end to a shadow list.
// - Commits the shadow list to the display bus only at vertical-blank entry, so no frame shows a half-updated list.
// PARAMETERS
// - SLOTS     12      number of list slots (product_IDS width = SLOTS*ID_W)
// - ID_W      4       bits per product ID
// - V_ACTIVE  480     first V_counter value outside the active area (blank entry line)
// - EMPTY_ID  4'hF    ID written to unused slots; renders as blank
// PORTS
// - CLK          in   1        pixel/system clock, rising edge
// - RST_N        in   1        asynchronous, active-low reset
// - cmd_valid    in   1        command present
// - cmd_ready    out  1        block can accept a command this cycle
// - cmd_op       in   2        00 ADD, 01 REMOVE_LAST, 10 CLEAR, 11 NOP
// - cmd_id       in   ID_W     product ID for ADD
// - V_counter    in   10       VGA vertical counter (same as text_controller)
// - product_IDS  out  48       display list; slot0 = [47:44] ... slot11 = [3:0]
// - count        out  4        valid entries in shadow list, 0..12
// - full         out  1        count == SLOTS
// - empty        out  1        count == 0
// - cmd_err      out  1        1-cycle pulse: command rejected
// - commit       out  1        1-cycle pulse: product_IDS updated this cycle
// BEHAVIOUR
// - Reset values (async, while RST_N=0):
//   - product_IDS and shadow = all EMPTY_ID (48'hFFFF_FFFF_FFFF).
//   - count=0, empty=1, full=0, cmd_err=0, commit=0, dirty=0.
//   - FSM=IDLE, cmd_ready=1 after release.
//   - Reset mid-operation discards any pending APPLY and any uncommitted changes.
// - FSM, two states:
//   - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches op/id and moves to APPLY.
//   - APPLY: cmd_ready=0. Executes the latched op on the shadow list, then returns to IDLE.
//   - Throughput is one command per 2 cycles.
// - Ops in APPLY:
//   - ADD: if !full and id!=EMPTY_ID, shadow[count]=id, count+1, dirty=1. Otherwise cmd_err=1, no other change.
//   - REMOVE_LAST: if !empty, shadow[count-1]=EMPTY_ID, count-1, dirty=1. If empty: cmd_err=1, no change.
//   - CLEAR: all slots EMPTY_ID, count=0, dirty=1 (even when already empty).
//   - NOP: no change, no error.
// - Slot order is append-only from slot0. Occupied slots are always contiguous from slot0.
// - full, empty and count are combinational from the registered count and reflect the shadow list.
// - Commit:
//   - Blank-entry strobe = (V_counter==V_ACTIVE) & (V_counter_q!=V_ACTIVE). V_counter_q is a 1-cycle delayed register.
//   - On the strobe with dirty=1: product_IDS<=shadow (value at start of cycle), commit=1, dirty cleared.
//   - On the strobe with dirty=0: no update, commit=0.
//   - APPLY coinciding with the strobe: commit takes the pre-APPLY shadow. dirty stays 1, so the new change commits next frame.
// - Latency: command accepted at T, shadow/count valid at T+2, product_IDS changes at the first blank-entry strobe at or after T+2.
// - cmd_op/cmd_id are sampled only on the accept edge. The front-end need not hold them afterwards.
// TESTING
// - Reset, 3 frames, no cmds -> product_IDS=48'hFFFF_FFFF_FFFF, commit never pulses, empty=1.
// - ADD 3, ADD 7, then blank entry -> one commit pulse, product_IDS[47:40]=8'h37, rest F, count=2.
// - 12 ADDs of 1, then a 13th ADD -> full=1, 13th gives cmd_err pulse, count stays 12, list unchanged.
// - REMOVE_LAST on empty -> cmd_err; CLEAR on 5 entries -> count=0, all F committed at next blank.
// - ADD accepted so APPLY lands on the strobe cycle -> old list committed now, new ID one frame later.
// - RST_N low mid-APPLY with uncommitted changes -> outputs return to reset values immediately, no commit afterward.

Source files
------------

// File: rtl/product_list_scheduler.sv
// Product ID list scheduler: applies terminal add/remove/clear commands to a
// shadow list and commits it to the text display bus on vertical-blank entry.
module product_list_scheduler #(
    parameter int unsigned       SLOTS    = 12,
    parameter int unsigned       ID_W     = 4,
    parameter int unsigned       V_ACTIVE = 480,
    parameter logic [ID_W-1:0]   EMPTY_ID = '1,
    localparam int unsigned      CNT_W    = $clog2(SLOTS + 1)
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [ID_W-1:0]         cmd_id,
    input  logic [9:0]              V_counter,
    output logic [SLOTS*ID_W-1:0]   product_IDS,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    cmd_err,
    output logic                    commit
);

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD         = 2'b00,
        OP_REMOVE_LAST = 2'b01,
        OP_CLEAR       = 2'b10,
        OP_NOP         = 2'b11
    } op_t;

    state_t                  state;
    op_t                     op_q;
    logic [ID_W-1:0]         id_q;
    logic [ID_W-1:0]         shadow [SLOTS];
    logic [CNT_W-1:0]        cnt_q;
    logic                    dirty;
    logic [9:0]              v_q;
    logic [SLOTS*ID_W-1:0]   shadow_flat;
    logic                    strobe;

    assign strobe = (V_counter == 10'(V_ACTIVE)) && (v_q != 10'(V_ACTIVE));
    assign count  = cnt_q;
    assign full   = (cnt_q == CNT_W'(SLOTS));
    assign empty  = (cnt_q == '0);

    // slot0 occupies the most significant ID_W bits of the display bus
    always_comb begin
        shadow_flat = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            shadow_flat[(SLOTS-1-i)*ID_W +: ID_W] = shadow[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            op_q        <= OP_NOP;
            id_q        <= EMPTY_ID;
            for (int unsigned i = 0; i < SLOTS; i++) begin
                shadow[i] <= EMPTY_ID;
            end
            cnt_q       <= '0;
            dirty       <= 1'b0;
            v_q         <= '0;
            product_IDS <= {SLOTS{EMPTY_ID}};
            cmd_err     <= 1'b0;
            commit      <= 1'b0;
        end else begin
            v_q     <= V_counter;
            cmd_err <= 1'b0;
            commit  <= 1'b0;

            // Commit samples the shadow as it stood at the start of the cycle;
            // a change applied in the same cycle re-asserts dirty below, which
            // overrides this clear so it commits on the following frame.
            if (strobe && dirty) begin
                product_IDS <= shadow_flat;
                commit      <= 1'b1;
                dirty       <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= op_t'(cmd_op);
                        id_q      <= cmd_id;
                        state     <= APPLY;
                        cmd_ready <= 1'b0;
                    end
                end
                APPLY: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    case (op_q)
                        OP_ADD: begin
                            if (!full && id_q != EMPTY_ID) begin
                                for (int unsigned i = 0; i < SLOTS; i++) begin
                                    if (CNT_W'(i) == cnt_q) shadow[i] <= id_q;
                                end
                                cnt_q <= cnt_q + CNT_W'(1);
                                dirty <= 1'b1;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                        OP_REMOVE_LAST: begin
                            if (cnt_q != '0) begin
                                for (int unsigned i = 0; i < SLOTS; i++) begin
                                    if (CNT_W'(i + 1) == cnt_q) shadow[i] <= EMPTY_ID;
                                end
                                cnt_q <= cnt_q - CNT_W'(1);
                                dirty <= 1'b1;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            for (int unsigned i = 0; i < SLOTS; i++) begin
                                shadow[i] <= EMPTY_ID;
                            end
                            cnt_q <= '0;
                            dirty <= 1'b1;
                        end
                        OP_NOP: begin
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_list_scheduler.sv
// Self-checking bench for product_list_scheduler: directed scenarios plus a
// randomized command stream checked against a queue-based list model.
module tb_product_list_scheduler;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b11;
    logic [3:0]  cmd_id = 4'h0;
    logic [9:0]  V_counter = 10'd100;
    logic [47:0] product_IDS;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        cmd_err;
    logic        commit;

    int errors = 0;
    int checks = 0;

    // Reference model: what the terminal has built, what the screen shows,
    // and whether the screen is stale.
    logic [3:0]  mlist [$];
    logic [47:0] mdisp = 48'hFFFF_FFFF_FFFF;
    bit          mdirty = 0;

    product_list_scheduler #(
        .SLOTS(12),
        .ID_W(4),
        .V_ACTIVE(480),
        .EMPTY_ID(4'hF)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_id(cmd_id),
        .V_counter(V_counter),
        .product_IDS(product_IDS),
        .count(count),
        .full(full),
        .empty(empty),
        .cmd_err(cmd_err),
        .commit(commit)
    );

    always #5 CLK = ~CLK;

    function automatic logic [47:0] pack_list();
        logic [47:0] v = 48'hFFFF_FFFF_FFFF;
        for (int i = 0; i < mlist.size(); i++) v[47-4*i -: 4] = mlist[i];
        return v;
    endfunction

    // Issue one command from a negedge; returns at the negedge two cycles
    // after the accept cycle, when the result must be visible.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] id);
        bit exp_err = 0;
        int waited = 0;
        while (!cmd_ready && waited < 10) begin
            @(negedge CLK);
            waited++;
        end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_ready_timeout: got %0b want 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_id    = id;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_id    = 4'($urandom);
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL apply_cycle: ready=%0b err=%0b want ready=0 err=0", cmd_ready, cmd_err);
        end
        case (op)
            2'b00: if (mlist.size() == 12 || id == 4'hF) exp_err = 1;
                   else begin mlist.push_back(id); mdirty = 1; end
            2'b01: if (mlist.size() == 0) exp_err = 1;
                   else begin void'(mlist.pop_back()); mdirty = 1; end
            2'b10: begin mlist.delete(); mdirty = 1; end
            default: ;
        endcase
        @(negedge CLK);
        checks++;
        if (cmd_err !== exp_err || count !== 4'(mlist.size()) ||
            full !== (mlist.size() == 12) || empty !== (mlist.size() == 0)) begin
            errors++;
            $display("FAIL cmd_result op=%0d id=%h: err=%0b count=%0d full=%0b empty=%0b want err=%0b count=%0d",
                     op, id, cmd_err, count, full, empty, exp_err, mlist.size());
        end
        checks++;
        if (commit !== 1'b0 || product_IDS !== mdisp) begin
            errors++;
            $display("FAIL no_commit_mid_frame: commit=%0b bus=%h want commit=0 bus=%h", commit, product_IDS, mdisp);
        end
    endtask

    task automatic blank_entry();
        bit exp_commit;
        V_counter = 10'd479;
        @(negedge CLK);
        V_counter = 10'd480;
        exp_commit = mdirty;
        if (mdirty) begin
            mdisp  = pack_list();
            mdirty = 0;
        end
        @(negedge CLK);
        checks++;
        if (commit !== exp_commit || product_IDS !== mdisp) begin
            errors++;
            $display("FAIL blank_commit: commit=%0b bus=%h want commit=%0b bus=%h", commit, product_IDS, exp_commit, mdisp);
        end
        @(negedge CLK);
        checks++;
        if (commit !== 1'b0) begin
            errors++;
            $display("FAIL commit_pulse_width: commit=%0b want 0", commit);
        end
        V_counter = 10'd100;
        @(negedge CLK);
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if (product_IDS !== 48'hFFFF_FFFF_FFFF || count !== 4'd0 || empty !== 1'b1 ||
            full !== 1'b0 || cmd_err !== 1'b0 || commit !== 1'b0) begin
            errors++;
            $display("FAIL %s: bus=%h count=%0d empty=%0b full=%0b err=%0b commit=%0b want FFFFFFFFFFFF/0/1/0/0/0",
                     tag, product_IDS, count, empty, full, cmd_err, commit);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset_values("reset_values");
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: got %0b want 1", cmd_ready);
        end
        repeat (3) blank_entry();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL idle_frames_empty: got %0b want 1", empty);
        end
    endtask

    task automatic test_add_two();
        do_cmd(2'b00, 4'h3);
        do_cmd(2'b00, 4'h7);
        blank_entry();
        checks++;
        if (product_IDS !== 48'h37FF_FFFF_FFFF || count !== 4'd2) begin
            errors++;
            $display("FAIL add_two: bus=%h count=%0d want 37FFFFFFFFFF count=2", product_IDS, count);
        end
    endtask

    task automatic test_full();
        do_cmd(2'b10, 4'h0);
        blank_entry();
        for (int i = 0; i < 12; i++) do_cmd(2'b00, 4'h1);
        do_cmd(2'b00, 4'h1);
        checks++;
        if (full !== 1'b1 || count !== 4'd12) begin
            errors++;
            $display("FAIL full_list: full=%0b count=%0d want 1/12", full, count);
        end
        blank_entry();
        checks++;
        if (product_IDS !== 48'h1111_1111_1111) begin
            errors++;
            $display("FAIL full_commit: bus=%h want 111111111111", product_IDS);
        end
    endtask

    task automatic test_remove_clear();
        do_cmd(2'b10, 4'h0);
        blank_entry();
        do_cmd(2'b01, 4'h0);
        do_cmd(2'b00, 4'hF);
        for (int i = 0; i < 5; i++) do_cmd(2'b00, 4'(i + 2));
        do_cmd(2'b01, 4'h0);
        do_cmd(2'b00, 4'h9);
        blank_entry();
        checks++;
        if (product_IDS !== 48'h2345_9FFF_FFFF) begin
            errors++;
            $display("FAIL remove_last: bus=%h want 23459FFFFFFF", product_IDS);
        end
        do_cmd(2'b10, 4'h0);
        do_cmd(2'b11, 4'h4);
        blank_entry();
        checks++;
        if (product_IDS !== 48'hFFFF_FFFF_FFFF || count !== 4'd0) begin
            errors++;
            $display("FAIL clear_commit: bus=%h count=%0d want FFFFFFFFFFFF/0", product_IDS, count);
        end
        do_cmd(2'b10, 4'h0);
        blank_entry();
    endtask

    task automatic test_apply_on_strobe();
        logic [47:0] old_list;
        do_cmd(2'b00, 4'hA);
        old_list = pack_list();
        V_counter = 10'd479;
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_id    = 4'hB;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        cmd_id    = 4'h0;
        @(negedge CLK);
        V_counter = 10'd480;
        @(negedge CLK);
        mdisp = old_list;
        mlist.push_back(4'hB);
        mdirty = 1;
        checks++;
        if (commit !== 1'b1 || product_IDS !== old_list || count !== 4'(mlist.size())) begin
            errors++;
            $display("FAIL collide_commit: commit=%0b bus=%h count=%0d want 1/%h/%0d",
                     commit, product_IDS, count, old_list, mlist.size());
        end
        @(negedge CLK);
        V_counter = 10'd100;
        @(negedge CLK);
        blank_entry();
        checks++;
        if (product_IDS[47:40] !== 8'hAB) begin
            errors++;
            $display("FAIL collide_next_frame: bus=%h want AB in top slots", product_IDS);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [1:0] op;
            logic [3:0] id;
            int r = int'($urandom_range(0, 9));
            op = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            id = 4'($urandom);
            do_cmd(op, id);
            if ($urandom_range(0, 5) == 0) blank_entry();
        end
        blank_entry();
    endtask

    task automatic test_reset_mid_apply();
        do_cmd(2'b00, 4'h5);
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_id    = 4'h6;
        @(posedge CLK);
        #1;
        cmd_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_reset_values("reset_mid_apply");
        mlist.delete();
        mdisp  = 48'hFFFF_FFFF_FFFF;
        mdirty = 0;
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (cmd_ready !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL ready_after_mid_reset: ready=%0b count=%0d want 1/0", cmd_ready, count);
        end
        blank_entry();
    endtask

    initial begin
        test_reset();
        test_add_two();
        test_full();
        test_remove_clear();
        test_apply_on_strobe();
        test_random();
        test_reset_mid_apply();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
